// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle control unit for the xgriscv core. Each instruction walks
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, with ready/req
//   handshakes toward instruction and data memory. Unknown opcodes park the
//   FSM in TRAP until reset. aluop and wb_sel keep the single-cycle encodings
//   so the datapath muxes are shared with the single-cycle core.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   opcode             IR[6:0], looked at only in DECODE
//   imem_ready         instruction word valid (FETCH only)
//   dmem_ready         data access complete (MEM only)
//   branch_taken       ALU compare result (EXEC only)
//   imem_req, ir_write instruction fetch request / IR load
//   dmem_req, mem_we   data request / store enable
//   alu_src, aluop     ALU operand select / ALU decoder class
//   reg_write, wb_sel  register write strobe / writeback source
//   pc_write, pc_src   PC update strobe / PC source select
//   instr_retired      one-cycle pulse per completed instruction
//   illegal_instr      sticky trap flag
//   state              current FSM state (debug)
//   cycle_count        cycles since reset
//   instret_count      retired instructions since reset

module multicycle_control #(
  parameter int ALUOP_W = 2,
  parameter int WBSEL_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  input  logic               branch_taken,
  output logic               imem_req,
  output logic               ir_write,
  output logic               dmem_req,
  output logic               mem_we,
  output logic               alu_src,
  output logic [ALUOP_W-1:0] aluop,
  output logic               reg_write,
  output logic [WBSEL_W-1:0] wb_sel,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               instr_retired,
  output logic               illegal_instr,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   instret_count
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_R      = 4'd0,
    CL_LOAD   = 4'd1,
    CL_STORE  = 4'd2,
    CL_BRANCH = 4'd3,
    CL_OPIMM  = 4'd4,
    CL_JALR   = 4'd5,
    CL_JAL    = 4'd6,
    CL_LUI    = 4'd7,
    CL_AUIPC  = 4'd8
  } iclass_t;

  state_t      state_q, state_d;
  iclass_t     class_q, class_d, dec_class;
  logic        dec_legal;
  logic        cls_alu_src;
  logic [1:0]  cls_aluop;
  logic [1:0]  aluop_c;
  logic [2:0]  wb_sel_c;

  // Opcode classifier, only consulted while in DECODE.
  always_comb begin
    dec_class = CL_R;
    dec_legal = 1'b1;
    case (opcode)
      7'b0110011: dec_class = CL_R;
      7'b0000011: dec_class = CL_LOAD;
      7'b0100011: dec_class = CL_STORE;
      7'b1100011: dec_class = CL_BRANCH;
      7'b0010011: dec_class = CL_OPIMM;
      7'b1100111: dec_class = CL_JALR;
      7'b1101111: dec_class = CL_JAL;
      7'b0110111: dec_class = CL_LUI;
      7'b0010111: dec_class = CL_AUIPC;
      default:    dec_legal = 1'b0;
    endcase
  end

  // ALU operand select and decoder class for the latched instruction.
  // MEM reuses these so the address computation stays stable during waits.
  always_comb begin
    cls_alu_src = 1'b0;
    cls_aluop   = 2'b00;
    case (class_q)
      CL_R:                              cls_aluop   = 2'b10;
      CL_OPIMM: begin
        cls_alu_src = 1'b1;
        cls_aluop   = 2'b11;
      end
      CL_BRANCH:                         cls_aluop   = 2'b01;
      CL_LOAD, CL_STORE, CL_JALR, CL_JAL: cls_alu_src = 1'b1;
      default: ;
    endcase
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    class_d       = class_q;
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    dmem_req      = 1'b0;
    mem_we        = 1'b0;
    alu_src       = 1'b0;
    aluop_c       = 2'b00;
    reg_write     = 1'b0;
    wb_sel_c      = 3'b000;
    pc_write      = 1'b0;
    pc_src        = 2'b00;
    instr_retired = 1'b0;

    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        if (dec_legal) begin
          class_d = dec_class;
          state_d = EXEC;
        end else begin
          state_d = TRAP;
        end
      end
      EXEC: begin
        alu_src = cls_alu_src;
        aluop_c = cls_aluop;
        case (class_q)
          CL_BRANCH: begin
            pc_write      = 1'b1;
            pc_src        = branch_taken ? 2'b01 : 2'b00;
            instr_retired = 1'b1;
            state_d       = FETCH;
          end
          CL_LOAD, CL_STORE: state_d = MEM;
          default:           state_d = WB;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        mem_we   = (class_q == CL_STORE);
        alu_src  = cls_alu_src;
        aluop_c  = cls_aluop;
        if (dmem_ready) begin
          if (class_q == CL_STORE) begin
            pc_write      = 1'b1;
            instr_retired = 1'b1;
            state_d       = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        reg_write     = 1'b1;
        pc_write      = 1'b1;
        instr_retired = 1'b1;
        state_d       = FETCH;
        case (class_q)
          CL_R, CL_OPIMM:  wb_sel_c = 3'b001;
          CL_LOAD:         wb_sel_c = 3'b011;
          CL_JAL: begin
            wb_sel_c = 3'b010;
            pc_src   = 2'b10;
          end
          CL_JALR: begin
            wb_sel_c = 3'b010;
            pc_src   = 2'b11;
          end
          CL_LUI:          wb_sel_c = 3'b110;
          CL_AUIPC:        wb_sel_c = 3'b111;
          default: ;
        endcase
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase

    // Outputs are decoded from the registered state, so without this gate a
    // reset arriving mid-handshake would still show the old requests.
    if (reset) begin
      imem_req      = 1'b0;
      ir_write      = 1'b0;
      dmem_req      = 1'b0;
      mem_we        = 1'b0;
      alu_src       = 1'b0;
      aluop_c       = 2'b00;
      reg_write     = 1'b0;
      wb_sel_c      = 3'b000;
      pc_write      = 1'b0;
      pc_src        = 2'b00;
      instr_retired = 1'b0;
    end
  end

  assign aluop  = ALUOP_W'(aluop_c);
  assign wb_sel = WBSEL_W'(wb_sel_c);
  assign state  = state_q;

  // State, class, trap flag and free-running counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      class_q       <= CL_R;
      illegal_instr <= 1'b0;
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      state_q     <= state_d;
      class_q     <= class_d;
      cycle_count <= cycle_count + CNT_W'(1);
      if (state_d == TRAP) begin
        illegal_instr <= 1'b1;
      end
      if (instr_retired) begin
        instret_count <= instret_count + CNT_W'(1);
      end
    end
  end

endmodule
